approx_mult_pipe: RTL and testbench

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pipe.sv | 137 +++++++++++++
 tb/tb_approx_mult_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// Unsigned WIDTHxWIDTH multiplier: 3 register stages. In approximate mode the low APPROX_COLS product columns are replaced by column ORs.
// The acceptance edge loads S1, so the product is visible after the third edge. When out_valid=1 and out_ready=0, every stage holds and in_ready drops.
module approx_mult_pipe #(
  parameter int WIDTH       = 6,
  parameter int APPROX_COLS = 6,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 p_mode,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     approx_cnt
);

  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;

  logic                         s1_vld_q, s2_vld_q, s3_vld_q;
  logic                         s1_mode_q, s2_mode_q, s3_mode_q;
  logic [WIDTH-1:0][WIDTH-1:0]  pp_d, pp_q;
  logic [PW-1:0]                sum_d, sum_q, carry_d, carry_q;
  logic [PW-1:0]                lo_or, hi_a, hi_b;
  logic [PW-1:0]                p_d, p_q;
  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic                         adv, accept;

  assign adv      = !s3_vld_q || out_ready;
  assign accept   = in_valid && adv;
  assign in_ready = adv;

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][j] = a[i] & b[j];
      end
    end
  end

  // Approximated columns only ever land in lo_or, so the two exact half-sums
  // have zero low bits and their final addition cannot carry out of them.
  always_comb begin
    lo_or = '0;
    hi_a  = '0;
    hi_b  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (s1_mode_q && ((i + j) < APPROX_COLS)) begin
          lo_or = lo_or | (PW'(pp_q[i][j]) << (i + j));
        end else if (i < HALF) begin
          hi_a = hi_a + (PW'(pp_q[i][j]) << (i + j));
        end else begin
          hi_b = hi_b + (PW'(pp_q[i][j]) << (i + j));
        end
      end
    end
    sum_d   = lo_or | hi_a;
    carry_d = hi_b;
  end

  assign p_d = sum_q + carry_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && mode && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      pp_q      <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        pp_q      <= pp_d;
        s1_mode_q <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_mode_q <= 1'b0;
      sum_q     <= '0;
      carry_q   <= '0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        sum_q     <= sum_d;
        carry_q   <= carry_d;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld_q  <= 1'b0;
      s3_mode_q <= 1'b0;
      p_q       <= '0;
    end else if (adv) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        p_q       <= p_d;
        s3_mode_q <= s2_mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s3_vld_q;
  assign p          = p_q;
  assign p_mode     = s3_mode_q;
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed table and corner sequences on a 6-bit instance, plus random streams on parameter-corner instances.
module tb_approx_mult_pipe;

  localparam int RAND_CYC = 2500;
  localparam int N_RND    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic        rst, in_valid, in_ready, mode, out_valid, out_ready, p_mode, cnt_clr;
  logic [5:0]  a, b;
  logic [11:0] p;
  logic [1:0]  approx_cnt;

  approx_mult_pipe #(.WIDTH(6), .APPROX_COLS(6), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .p_mode(p_mode), .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic        mode;
    logic [11:0] p;
  } vec_t;

  vec_t tbl[10];

  for (genvar g = 0; g < N_RND; g++) begin : g_rnd
    localparam int W = (g < 2) ? 4 : (g == 2) ? 6 : (g == 3) ? 8 : 16;
    localparam int C = (g == 0) ? 0 : (g == 1) ? 7 : (g == 2) ? 6 : (g == 3) ? 3 : (g == 4) ? 31 : 0;

    logic           r_rst, iv, ir, md, ov, ordy, pm, clr;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rp;
    logic [15:0]    cnt;

    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(C), .CNT_W(16)) u_rnd (
      .clk(clk), .rst(r_rst), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .mode(md), .out_valid(ov), .out_ready(ordy),
      .p(rp), .p_mode(pm), .cnt_clr(clr), .approx_cnt(cnt)
    );

    // Approximate value = exact product, minus the true weight of the low
    // columns, plus one unit per low column that holds any set bit.
    function automatic logic [2*W-1:0] ref_p(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      longint unsigned prod, lo_cnt, lo_or;
      int n;
      prod = x * y;
      if (!m) return prod[2*W-1:0];
      lo_cnt = 0;
      lo_or  = 0;
      for (int k = 0; k < C; k++) begin
        n = 0;
        for (int i = 0; i < W; i++) begin
          if ((k - i >= 0) && (k - i < W)) n += int'(x[i] & y[k-i]);
        end
        lo_cnt += longint'(n) << k;
        if (n != 0) lo_or += 64'd1 << k;
      end
      prod = prod - lo_cnt + lo_or;
      return prod[2*W-1:0];
    endfunction

    initial begin : drv
      logic [2*W:0] q[$];
      logic [2*W:0] e;
      logic [15:0]  cnt_m;
      r_rst = 1'b1; iv = 1'b0; ordy = 1'b0; clr = 1'b0; md = 1'b0; ra = '0; rb = '0;
      cnt_m = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      r_rst = 1'b0;
      for (int c = 0; c < RAND_CYC + 20; c++) begin
        @(negedge clk);
        if (c < RAND_CYC) begin
          iv   = ($urandom_range(0, 4) != 0);
          ra   = W'($urandom);
          rb   = W'($urandom);
          if ($urandom_range(0, 7) == 0) ra = '1;
          if ($urandom_range(0, 7) == 0) rb = '1;
          if ($urandom_range(0, 15) == 0) rb = '0;
          md   = 1'($urandom_range(0, 1));
          ordy = ($urandom_range(0, 3) != 0);
          clr  = ($urandom_range(0, 63) == 0);
        end else begin
          iv = 1'b0; ordy = 1'b1; clr = 1'b0;
        end
        #1;
        check("rnd_in_ready", ir, !ov || ordy);
        if (ov && ordy) begin
          if (q.size() == 0) begin
            check("rnd_extra_output", ov, 0);
          end else begin
            e = q.pop_front();
            check("rnd_p", rp, e[2*W-1:0]);
            check("rnd_p_mode", pm, e[2*W]);
          end
        end
        if (c % 16 == 0) check("rnd_cnt", cnt, cnt_m);
        if (iv && ir) q.push_back({md, ref_p(ra, rb, md)});
        if (clr) cnt_m = '0;
        else if (iv && ir && md && cnt_m != 16'hffff) cnt_m++;
      end
      check("rnd_drain", q.size(), 0);
      done_cnt++;
    end
  end

  initial begin : main
    logic [5:0]  sa[4];
    logic [5:0]  sb[4];
    logic [11:0] sp[4];
    logic [11:0] got[$];
    int idx, stall, stale;

    tbl[0] = '{6'd63, 6'd63, 1'b0, 12'd3969};
    tbl[1] = '{6'd63, 6'd63, 1'b1, 12'd3711};
    tbl[2] = '{6'd1,  6'd45, 1'b1, 12'd45};
    tbl[3] = '{6'd0,  6'd63, 1'b0, 12'd0};
    tbl[4] = '{6'd0,  6'd63, 1'b1, 12'd0};
    tbl[5] = '{6'd45, 6'd1,  1'b0, 12'd45};
    tbl[6] = '{6'd3,  6'd3,  1'b1, 12'd7};
    tbl[7] = '{6'd7,  6'd7,  1'b1, 12'd31};
    tbl[8] = '{6'd7,  6'd7,  1'b0, 12'd49};
    tbl[9] = '{6'd10, 6'd12, 1'b1, 12'd120};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_p_mode", p_mode, 0);
    check("rst_cnt", approx_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; mode = tbl[i].mode; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_s1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_s2", out_valid, 0);
      @(posedge clk); #1;
      check("tbl_valid", out_valid, 1);
      check("tbl_p", p, tbl[i].p);
      check("tbl_p_mode", p_mode, tbl[i].mode);
    end

    // Four back-to-back beats with a five-cycle output stall.
    sa = '{6'd3, 6'd7, 6'd11, 6'd63};
    sb = '{6'd5, 6'd9, 6'd13, 6'd2};
    sp = '{12'd15, 12'd63, 12'd143, 12'd126};
    idx = 0; stall = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      in_valid = (idx < 4);
      if (idx < 4) begin a = sa[idx]; b = sb[idx]; mode = 1'b0; end
      out_ready = !(out_valid && stall < 5);
      #1;
      if (!out_ready) begin
        stall++;
        check("stall_in_ready", in_ready, 0);
        check("stall_p_held", p, sp[0]);
      end
      if (out_valid && out_ready) got.push_back(p);
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_cycles", stall, 5);
    check("stall_count", got.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) check("stall_order", got[k], sp[k]);
    end

    // Saturating counter and clear-over-increment priority.
    @(negedge clk);
    cnt_clr = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("cnt_clr", approx_cnt, 0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      cnt_clr = 1'b0; in_valid = 1'b1; mode = 1'b1; a = 6'(n); b = 6'd5; out_ready = 1'b1;
      @(posedge clk); #1;
      check("cnt_sat", approx_cnt, (n < 3) ? n : 3);
    end
    @(negedge clk);
    cnt_clr = 1'b1; in_valid = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    check("cnt_clr_priority", approx_cnt, 0);
    @(negedge clk);
    cnt_clr = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 6'(k + 1); b = 6'd3; mode = 1'b1; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", p, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cnt", approx_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);

    for (int t = 0; t < 10000 && done_cnt < N_RND; t++) @(posedge clk);
    check("rnd_done", done_cnt, N_RND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
